// File: rtl/color_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : color_pkg
//  Brief    : Shared colour class encoding, window FSM states and compare helper
//  Revision : 1.0 - initial release
// ============================================================================
package color_pkg;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_R    = 2'd1,
        CLS_G    = 2'd2,
        CLS_B    = 2'd3
    } color_class_t;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_acc   = 2'd1;
    localparam logic [1:0] c_st_avg   = 2'd2;
    localparam logic [1:0] c_st_class = 2'd3;

    // Magnitude test first so the subtraction can never wrap.
    function automatic logic beats(input logic [15:0] a,
                                   input logic [15:0] b,
                                   input logic [15:0] margin);
        beats = (a > b) && ((a - b) >= margin);
    endfunction

endpackage
`default_nettype wire

// File: rtl/color_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : color_debounce
//  Brief    : Candidate/stability tracking, committed class and change pulse
//  Revision : 1.0 - initial release
// ============================================================================
module color_debounce
    import color_pkg::*;
#(
    parameter int STABLE_CNT = 3
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_dec_valid,
    input  color_class_t i_decision,
    input  logic         i_timeout,
    output logic         o_class_chg,
    output logic [2:0]   o_onehot
);

    localparam logic [3:0] c_stable_max = 4'(STABLE_CNT);

    color_class_t r_cand;
    color_class_t r_comm;
    logic [3:0]   r_stable;
    logic         r_class_chg;
    logic [2:0]   r_onehot;

    color_class_t w_cand_nxt;
    color_class_t w_comm_nxt;
    logic [3:0]   w_stable_nxt;
    logic         w_chg_nxt;
    logic [2:0]   w_onehot_nxt;

    always_comb begin
        w_cand_nxt   = r_cand;
        w_stable_nxt = r_stable;
        w_comm_nxt   = r_comm;
        w_chg_nxt    = 1'b0;
        if (i_timeout) begin
            w_cand_nxt   = CLS_NONE;
            w_stable_nxt = '0;
            if (r_comm != CLS_NONE) begin
                w_comm_nxt = CLS_NONE;
                w_chg_nxt  = 1'b1;
            end
        end else if (i_dec_valid) begin
            if (i_decision == r_cand) begin
                if (r_stable < c_stable_max) begin
                    w_stable_nxt = r_stable + 4'(1);
                end
            end else begin
                w_cand_nxt   = i_decision;
                w_stable_nxt = 4'(1);
            end
            if ((w_stable_nxt == c_stable_max) && (w_cand_nxt != r_comm)) begin
                w_comm_nxt = w_cand_nxt;
                w_chg_nxt  = 1'b1;
            end
        end
    end

    // Outputs decode the next committed value so they land with class_chg.
    assign w_onehot_nxt = {w_comm_nxt == CLS_B, w_comm_nxt == CLS_G, w_comm_nxt == CLS_R};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand      <= CLS_NONE;
            r_comm      <= CLS_NONE;
            r_stable    <= '0;
            r_class_chg <= 1'b0;
            r_onehot    <= '0;
        end else begin
            r_cand      <= w_cand_nxt;
            r_comm      <= w_comm_nxt;
            r_stable    <= w_stable_nxt;
            r_class_chg <= w_chg_nxt;
            r_onehot    <= w_onehot_nxt;
        end
    end

    assign o_class_chg = r_class_chg;
    assign o_onehot    = r_onehot;

endmodule
`default_nettype wire

// File: rtl/color_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : color_classifier
//  Brief    : Window-averages raw RGB samples, classifies the dominant colour
//             and debounces it into one-hot valid levels
//  Revision : 1.0 - initial release
// ============================================================================
module color_classifier
    import color_pkg::*;
#(
    parameter int          AVG_LOG2    = 3,
    parameter logic [15:0] MIN_LEVEL   = 16'd200,
    parameter logic [15:0] MARGIN      = 16'd64,
    parameter int          STABLE_CNT  = 3,
    parameter int          TIMEOUT_CYC = 25000000
)(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        raw_valid,
    input  logic [15:0] raw_r,
    input  logic [15:0] raw_g,
    input  logic [15:0] raw_b,
    output logic        r_valid,
    output logic        g_valid,
    output logic        b_valid,
    output logic        class_chg
);

    localparam int                    c_sum_w    = 16 + AVG_LOG2;
    localparam int                    c_to_w     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AVG_LOG2-1:0]   c_cnt_last = '1;
    localparam logic [c_to_w-1:0]     c_to_last  = c_to_w'(TIMEOUT_CYC - 1);
    localparam logic [c_to_w-1:0]     c_to_max   = c_to_w'(TIMEOUT_CYC);

    logic [c_sum_w-1:0]  r_sum_r, r_sum_g, r_sum_b;
    logic [AVG_LOG2-1:0] r_cnt;
    logic [15:0]         r_avg_r, r_avg_g, r_avg_b;
    logic [c_to_w-1:0]   r_idle_cnt;
    logic [1:0]          r_state;
    color_class_t        r_decision;
    logic                r_dec_valid;

    logic [c_sum_w-1:0]  w_sum_r_nxt, w_sum_g_nxt, w_sum_b_nxt;
    logic                w_win_full;
    logic                w_timeout;
    logic [1:0]          w_state_nxt;
    logic                w_win_r, w_win_g, w_win_b;
    color_class_t        w_class;
    logic [2:0]          w_onehot;

    assign w_sum_r_nxt = r_sum_r + c_sum_w'(raw_r);
    assign w_sum_g_nxt = r_sum_g + c_sum_w'(raw_g);
    assign w_sum_b_nxt = r_sum_b + c_sum_w'(raw_b);

    assign w_win_full  = raw_valid && (r_cnt == c_cnt_last);
    // A sample arriving on the expiry cycle suppresses the timeout.
    assign w_timeout   = !raw_valid && (r_idle_cnt == c_to_last);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sum_r <= '0;
            r_sum_g <= '0;
            r_sum_b <= '0;
            r_cnt   <= '0;
            r_avg_r <= '0;
            r_avg_g <= '0;
            r_avg_b <= '0;
        end else if (raw_valid) begin
            if (w_win_full) begin
                r_sum_r <= '0;
                r_sum_g <= '0;
                r_sum_b <= '0;
                r_cnt   <= '0;
                r_avg_r <= 16'(w_sum_r_nxt >> AVG_LOG2);
                r_avg_g <= 16'(w_sum_g_nxt >> AVG_LOG2);
                r_avg_b <= 16'(w_sum_b_nxt >> AVG_LOG2);
            end else begin
                r_sum_r <= w_sum_r_nxt;
                r_sum_g <= w_sum_g_nxt;
                r_sum_b <= w_sum_b_nxt;
                r_cnt   <= r_cnt + AVG_LOG2'(1);
            end
        end else if (w_timeout) begin
            r_sum_r <= '0;
            r_sum_g <= '0;
            r_sum_b <= '0;
            r_cnt   <= '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_idle_cnt <= '0;
        end else if (raw_valid) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != c_to_max) begin
            r_idle_cnt <= r_idle_cnt + c_to_w'(1);
        end
    end

    // Window FSM: datapath keeps accepting samples in AVG/CLASS, so a new
    // window can start (or, for tiny windows, finish) while these run.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (raw_valid) w_state_nxt = c_st_acc;
            c_st_acc: begin
                if (w_win_full)     w_state_nxt = c_st_avg;
                else if (w_timeout) w_state_nxt = c_st_idle;
            end
            c_st_avg:   w_state_nxt = c_st_class;
            c_st_class: begin
                if (w_win_full)                       w_state_nxt = c_st_avg;
                else if (raw_valid || (r_cnt != '0))  w_state_nxt = c_st_acc;
                else                                  w_state_nxt = c_st_idle;
            end
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_win_r = (r_avg_r >= MIN_LEVEL) && beats(r_avg_r, r_avg_g, MARGIN)
                                            && beats(r_avg_r, r_avg_b, MARGIN);
    assign w_win_g = (r_avg_g >= MIN_LEVEL) && beats(r_avg_g, r_avg_r, MARGIN)
                                            && beats(r_avg_g, r_avg_b, MARGIN);
    assign w_win_b = (r_avg_b >= MIN_LEVEL) && beats(r_avg_b, r_avg_r, MARGIN)
                                            && beats(r_avg_b, r_avg_g, MARGIN);

    always_comb begin
        w_class = CLS_NONE;
        if (w_win_r)      w_class = CLS_R;
        else if (w_win_g) w_class = CLS_G;
        else if (w_win_b) w_class = CLS_B;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_decision  <= CLS_NONE;
            r_dec_valid <= 1'b0;
        end else begin
            r_dec_valid <= (r_state == c_st_avg);
            if (r_state == c_st_avg) begin
                r_decision <= w_class;
            end
        end
    end

    color_debounce #(
        .STABLE_CNT (STABLE_CNT)
    ) u_debounce (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .i_dec_valid (r_dec_valid),
        .i_decision  (r_decision),
        .i_timeout   (w_timeout),
        .o_class_chg (class_chg),
        .o_onehot    (w_onehot)
    );

    assign r_valid = w_onehot[0];
    assign g_valid = w_onehot[1];
    assign b_valid = w_onehot[2];

endmodule
`default_nettype wire

// File: tb/tb_color_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_color_classifier
//  Brief    : Scoreboard bench for color_classifier (8-sample windows, 1000-cycle timeout)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_color_classifier;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        raw_valid = 1'b0;
    logic [15:0] raw_r = '0, raw_g = '0, raw_b = '0;
    logic        r_valid, g_valid, b_valid, class_chg;

    always #5 sys_clk = ~sys_clk;

    color_classifier #(
        .AVG_LOG2    (3),
        .MIN_LEVEL   (16'd200),
        .MARGIN      (16'd64),
        .STABLE_CNT  (3),
        .TIMEOUT_CYC (1000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .raw_valid (raw_valid),
        .raw_r     (raw_r),
        .raw_g     (raw_g),
        .raw_b     (raw_b),
        .r_valid   (r_valid),
        .g_valid   (g_valid),
        .b_valid   (b_valid),
        .class_chg (class_chg)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int chg_seen = 0;
    int chg_exp  = 0;
    int m_cand = 0, m_stable = 0, m_comm = 0;
    int exp_avg_r = 0, exp_avg_g = 0, exp_avg_b = 0;
    logic [3:0] exp_q[$];
    int         due_q[$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference classification: signed differences, so a tie or loser fails the margin.
    function automatic int classify(input int r, input int g, input int b);
        int a[3];
        a[0] = r; a[1] = g; a[2] = b;
        for (int i = 0; i < 3; i++) begin
            bit ok;
            ok = (a[i] >= 200);
            for (int j = 0; j < 3; j++)
                if (j != i && (a[i] - a[j]) < 64) ok = 1'b0;
            if (ok) return i + 1;
        end
        return 0;
    endfunction

    task automatic model_step(input int d, output logic [3:0] e);
        logic chg;
        chg = 1'b0;
        if (d == m_cand) begin
            if (m_stable < 3) m_stable++;
        end else begin
            m_cand   = d;
            m_stable = 1;
        end
        if (m_stable == 3 && m_cand != m_comm) begin
            m_comm = m_cand;
            chg    = 1'b1;
            chg_exp++;
        end
        e = {chg, m_comm == 3, m_comm == 2, m_comm == 1};
    endtask

    task automatic send_window(input int r0, input int g0, input int b0,
                               input int rs, input int gs, input int bs, input int gap);
        int sr, sg, sb;
        logic [3:0] e;
        sr = 0; sg = 0; sb = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge sys_clk); #1;
            raw_valid = 1'b1;
            raw_r = 16'(r0 + i * rs);
            raw_g = 16'(g0 + i * gs);
            raw_b = 16'(b0 + i * bs);
            sr += r0 + i * rs;
            sg += g0 + i * gs;
            sb += b0 + i * bs;
            if (i == 7) begin
                exp_avg_r = sr / 8;
                exp_avg_g = sg / 8;
                exp_avg_b = sb / 8;
                model_step(classify(exp_avg_r, exp_avg_g, exp_avg_b), e);
                exp_q.push_back(e);
                due_q.push_back(cyc + 3);
            end else if (gap > 0) begin
                @(posedge sys_clk); #1;
                raw_valid = 1'b0;
                repeat (gap - 1) @(posedge sys_clk);
            end
        end
        @(posedge sys_clk); #1;
        raw_valid = 1'b0;
    endtask

    task automatic send_samples(input int n, input int r, input int g, input int b);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk); #1;
            raw_valid = 1'b1;
            raw_r = 16'(r); raw_g = 16'(g); raw_b = 16'(b);
        end
        @(posedge sys_clk); #1;
        raw_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(posedge sys_clk);
        #1;
    endtask

    // Output monitor: pops the expected result when its window is due.
    always @(negedge sys_clk) begin
        if (sys_rst_n && due_q.size() > 0 && cyc == due_q[0]) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            chk("win_r_valid", r_valid, e[0]);
            chk("win_g_valid", g_valid, e[1]);
            chk("win_b_valid", b_valid, e[2]);
            chk("win_class_chg", class_chg, e[3]);
        end
    end

    always @(negedge sys_clk) if (class_chg === 1'b1) chg_seen++;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_r_valid", r_valid, 0);
        chk("rst_g_valid", g_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_class_chg", class_chg, 0);
        sys_rst_n = 1'b1;

        // Margin too small, below MIN_LEVEL, exact tie: all NONE.
        repeat (3) send_window(300, 260, 0, 0, 0, 0, 0);
        repeat (3) send_window(0, 0, 150, 0, 0, 0, 0);
        repeat (3) send_window(900, 900, 0, 0, 0, 0, 0);
        settle();
        chk("none_chg_count", chg_seen, chg_exp);

        repeat (3) send_window(1000, 100, 100, 0, 0, 0, 1);
        settle();
        chk("red_commit", r_valid, 1);
        chk("red_chg_count", chg_seen, chg_exp);

        repeat (3) send_window(100, 1000, 100, 0, 0, 0, 0);
        send_window(1000, 100, 100, 0, 0, 0, 0);
        send_window(100, 1000, 100, 0, 0, 0, 0);
        send_window(1000, 100, 100, 0, 0, 0, 0);
        send_window(100, 1000, 100, 0, 0, 0, 0);
        repeat (3) send_window(1000, 100, 100, 0, 0, 0, 0);
        settle();
        chk("alt_chg_count", chg_seen, chg_exp);

        // Timeout with a partial window pending.
        send_samples(3, 0, 5000, 0);
        repeat (1100) @(posedge sys_clk);
        #1;
        m_cand = 0; m_stable = 0;
        if (m_comm != 0) begin m_comm = 0; chg_exp++; end
        chk("to_r_valid", r_valid, 0);
        chk("to_g_valid", g_valid, 0);
        chk("to_b_valid", b_valid, 0);
        chk("to_chg_count", chg_seen, chg_exp);
        send_window(100, 100, 2000, 0, 0, 0, 0);
        chk("to_avg_g", dut.r_avg_g, exp_avg_g);
        chk("to_avg_b", dut.r_avg_b, exp_avg_b);
        repeat (2) send_window(100, 100, 2000, 0, 0, 0, 0);
        settle();
        chk("blue_commit", b_valid, 1);

        // Async reset part-way through a window.
        send_samples(5, 0, 60000, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("arst_r_valid", r_valid, 0);
        chk("arst_g_valid", g_valid, 0);
        chk("arst_b_valid", b_valid, 0);
        m_cand = 0; m_stable = 0; m_comm = 0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        send_window(1000, 0, 50, 16, 1, 0, 0);
        chk("arst_avg_r", dut.r_avg_r, exp_avg_r);
        chk("arst_avg_g", dut.r_avg_g, exp_avg_g);
        chk("arst_avg_b", dut.r_avg_b, exp_avg_b);
        repeat (2) send_window(1000, 0, 50, 16, 1, 0, 0);
        settle();
        chk("final_r_valid", r_valid, 1);
        chk("final_chg_count", chg_seen, chg_exp);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
